// File: rtl/fp_pkg.sv
// Shared types and constants for the FP adder normalise/round stage.
package fp_pkg;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  localparam logic [7:0]  EXP_MAX       = 8'hFF;
  localparam int          BIAS          = 127;
  localparam int          MANT_W        = 24;
  localparam int          FRAC_W        = 23;
  localparam logic [22:0] QNAN_INF_FRAC = '0;
endpackage

// File: rtl/fp_lzc24.sv
// Combinational 24-bit leading-zero counter; o_count is 24 when i_data is zero.
module fp_lzc24 (
  input  logic [23:0] i_data,
  output logic [4:0]  o_count,
  output logic        o_zero
);
  logic w_found;

  always_comb begin
    o_count = 5'd0;
    w_found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!w_found) begin
        if (i_data[i]) w_found = 1'b1;
        else           o_count = o_count + 5'd1;
      end
    end
  end

  assign o_zero = ~|i_data;
endmodule

// File: rtl/fp_normalize_round.sv
// Normalise, round-to-nearest-even and pack an IEEE-754 single result.
// FP_NORM_LZC_EN: single-cycle left shift via leading-zero count instead of one bit per cycle.
module fp_normalize_round #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MANT_W:0]     in_sum,
  input  logic [EXP_W-1:0]    in_exp,
  input  logic                in_sign,
  input  logic [2:0]          in_grs,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result,
  output fp_pkg::state_t      o_dbg_state
);
  import fp_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its data stable while valid is high and ready is low.
  state_t           r_state;
  logic [MANT_W:0]  r_mant;
  logic [EXP_W:0]   r_exp;
  logic             r_g, r_r, r_s, r_sign;
  logic             r_in_ready, r_out_valid;
  logic [31:0]      r_result;

  logic [EXP_W:0]   w_exp_inc;
  logic             w_inc;
  logic [MANT_W:0]  w_mant_rnd;
  logic [31:0]      w_round_res;
  logic [MANT_W:0]  w_shl_mant;
  logic             w_shl_g, w_shl_r;
  logic [EXP_W:0]   w_shl_exp;
  state_t           w_shl_next;

  assign w_exp_inc  = r_exp + 9'd1;
  assign w_inc      = r_g & (r_r | r_s | r_mant[0]);
  assign w_mant_rnd = r_mant + {24'd0, w_inc};

  // A subnormal that rounds up into bit 23 naturally picks up exponent field 1.
  always_comb begin
    w_round_res = {r_sign, 8'd0, w_mant_rnd[22:0]};
    if (w_mant_rnd[24]) begin
      if (w_exp_inc == 9'd255) w_round_res = {r_sign, EXP_MAX, QNAN_INF_FRAC};
      else                     w_round_res = {r_sign, w_exp_inc[7:0], 23'd0};
    end else if (w_mant_rnd[23]) begin
      w_round_res = {r_sign, r_exp[7:0], w_mant_rnd[22:0]};
    end
  end

`ifdef FP_NORM_LZC_EN
  logic [4:0]  w_lz24;
  logic        w_lz_zero;
  logic [7:0]  w_lz, w_room, w_shamt;
  logic [25:0] w_shv;

  fp_lzc24 u_lzc (
    .i_data  (r_mant[23:0]),
    .o_count (w_lz24),
    .o_zero  (w_lz_zero)
  );

  // g and r take part in the count, so an all-zero mantissa still normalises exactly.
  assign w_lz       = w_lz_zero ? (r_g ? 8'd24 : (r_r ? 8'd25 : 8'd26)) : {3'd0, w_lz24};
  assign w_room     = r_exp[7:0] - 8'd1;
  assign w_shamt    = (w_lz < w_room) ? w_lz : w_room;
  assign w_shv      = {r_mant[23:0], r_g, r_r} << w_shamt;
  assign w_shl_mant = {1'b0, w_shv[25:2]};
  assign w_shl_g    = w_shv[1];
  assign w_shl_r    = w_shv[0];
  assign w_shl_exp  = r_exp - {1'b0, w_shamt};
  assign w_shl_next = ROUND;
`else
  assign w_shl_mant = {r_mant[23:0], r_g};
  assign w_shl_g    = r_r;
  assign w_shl_r    = 1'b0;
  assign w_shl_exp  = r_exp - 9'd1;
  assign w_shl_next = NORM;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mant      <= '0;
      r_exp       <= '0;
      r_g         <= 1'b0;
      r_r         <= 1'b0;
      r_s         <= 1'b0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_mant     <= in_sum;
            r_exp      <= {1'b0, in_exp};
            {r_g, r_r, r_s} <= in_grs;
            r_sign     <= in_sign;
            r_in_ready <= 1'b0;
            r_state    <= NORM;
          end
        end
        NORM: begin
          if (r_mant == '0 && {r_g, r_r, r_s} == 3'b000) begin
            r_result    <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_mant[24]) begin
            r_mant <= {1'b0, r_mant[24:1]};
            r_g    <= r_mant[0];
            r_r    <= r_g;
            r_s    <= r_s | r_r;
            r_exp  <= w_exp_inc;
            if (w_exp_inc == 9'd255) begin
              r_result    <= {r_sign, EXP_MAX, QNAN_INF_FRAC};
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= ROUND;
            end
          end else if (r_mant[23] || r_exp == 9'd1) begin
            r_state <= ROUND;
          end else begin
            r_mant  <= w_shl_mant;
            r_g     <= w_shl_g;
            r_r     <= w_shl_r;
            r_exp   <= w_shl_exp;
            r_state <= w_shl_next;
          end
        end
        ROUND: begin
          r_result    <= w_round_res;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_result  = r_result;
  assign o_dbg_state = r_state;
endmodule
